// File: rtl/jtopl_wrq.sv
// Write queue and pacer for the OPL2 core: buffers CPU port writes in a FIFO
// and replays them with the address/data settle gaps the chip needs.
module jtopl_wrq #(
  parameter int FIFO_AW   = 4,
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             cpu_we,
  input  logic             cpu_addr,
  input  logic [7:0]       cpu_din,
  input  logic             flush,
  output logic [7:0]       opl_din,
  output logic             opl_addr,
  output logic             opl_cs_n,
  output logic             opl_wr_n,
  output logic [FIFO_AW:0] level,
  output logic             busy,
  output logic             ovf
);

  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int MAX_WAIT = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  logic [8:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // level never exceeds DEPTH, so its top bit alone marks a full FIFO
  assign full  = level[FIFO_AW];
  assign empty = (level == '0);
  assign pop   = (state == S_IDLE) && cen && !empty;
  // a pop in the same clk frees the slot, so a push into a full FIFO still lands
  assign push  = cpu_we && (!full || pop) && !flush;
  assign busy  = (state != S_IDLE) || !empty;

  // NOTE: the storage array has no reset; its contents are only read through
  // pointers that reset does clear, so resetting it would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (cpu_we && full && !pop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opl_din  <= '0;
      opl_addr <= 1'b0;
      opl_cs_n <= 1'b1;
      opl_wr_n <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            opl_din  <= mem[rd_ptr][7:0];
            opl_addr <= mem[rd_ptr][8];
            opl_cs_n <= 1'b0;
            opl_wr_n <= 1'b0;
            state    <= S_STROBE;
          end
        end
        S_STROBE: begin
          if (cen) begin
            opl_cs_n <= 1'b1;
            opl_wr_n <= 1'b1;
            cnt      <= opl_addr ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cen) begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtopl_wrq.sv
// Self-checking bench for jtopl_wrq: a scoreboard queue holds the writes that
// must reach the core, and a monitor pops and compares on every strobe fall.
module tb_jtopl_wrq;

  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       cpu_we;
  logic       cpu_addr;
  logic [7:0] cpu_din;
  logic       flush;
  logic [7:0] opl_din;
  logic       opl_addr;
  logic       opl_cs_n;
  logic       opl_wr_n;
  logic [4:0] level;
  logic       busy;
  logic       ovf;

  jtopl_wrq #(.FIFO_AW(4), .ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .flush(flush), .opl_din(opl_din), .opl_addr(opl_addr),
    .opl_cs_n(opl_cs_n), .opl_wr_n(opl_wr_n), .level(level), .busy(busy),
    .ovf(ovf)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  int         fall_ticks[$];
  int         rise_ticks[$];
  int         busy_low_tick = 0;
  int         strobe_cnt = 0;
  int         tick = 0;
  logic       prev_wr_n = 1'b1;
  logic       prev_busy = 1'b0;

  // cen source: 0 = cen_force, 1 = one tick every 4 clk, 2 = tied high
  int   cen_mode = 0;
  logic cen_force = 1'b0;
  int   div = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (cen) tick++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Set cen for the coming posedge, then advance to the next negedge.
  task automatic step();
    case (cen_mode)
      1:       begin div = (div + 1) % 4; cen = (div == 0); end
      2:       cen = 1'b1;
      default: cen = cen_force;
    endcase
    @(negedge clk);
  endtask

  task automatic push(input logic a, input logic [7:0] d, input bit accept);
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    step();
    cpu_we = 1'b0;
    if (accept) exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    exp_q.delete();
    step();
  endtask

  task automatic wait_idle(input int max_clk, input string name);
    int n = 0;
    while (busy && n < max_clk) begin step(); n++; end
    check(name, busy, 0);
  endtask

  // Monitor: every strobe fall consumes one scoreboard entry.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      if (!opl_wr_n && prev_wr_n) begin
        strobe_cnt++;
        fall_ticks.push_back(tick);
        check("strobe_cs_n", opl_cs_n, 0);
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_entry", {opl_addr, opl_din}, e);
        end
      end
      if (opl_wr_n && !prev_wr_n) rise_ticks.push_back(tick);
      // first cen tick that observes busy low
      if (!busy && prev_busy) busy_low_tick = tick + 1;
    end
    prev_wr_n = opl_wr_n;
    prev_busy = busy;
  end

  initial begin
    int n;
    int s0;
    int f0;
    int busy_clk;
    int low_clk;

    rst = 1'b1; cen = 1'b0; cpu_we = 1'b0; cpu_addr = 1'b0; cpu_din = 8'h00; flush = 1'b0;
    step(); step();
    check("rst_cs_n", opl_cs_n, 1);
    check("rst_wr_n", opl_wr_n, 1);
    check("rst_din", opl_din, 0);
    check("rst_addr", opl_addr, 0);
    check("rst_level", level, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    step();

    // Address then data write, cen every 4 clk.
    cen_mode = 1;
    fall_ticks.delete(); rise_ticks.delete();
    push(1'b0, 8'h20, 1);
    push(1'b1, 8'h01, 1);
    wait_idle(600, "pace_idle");
    repeat (8) step();
    check("pace_falls", fall_ticks.size(), 2);
    check("pace_rises", rise_ticks.size(), 2);
    f0 = fall_ticks[0];
    check("pace_second_fall", fall_ticks[1] - f0, ADDR_WAIT + 2);
    check("pace_second_rise", rise_ticks[1] - f0, ADDR_WAIT + 3);
    check("pace_busy_drop", busy_low_tick - f0, 100);
    check("pace_last_addr", opl_addr, 1);
    check("pace_last_din", opl_din, 8'h01);

    // Fill with cen held low, then overflow.
    cen_mode = 0; cen_force = 1'b0;
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h40 + i), 0);
    check("fill_level", level, 16);
    check("fill_ovf", ovf, 0);
    push(1'b1, 8'hEE, 0);
    check("ovf_level", level, 16);
    check("ovf_set", ovf, 1);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush_level", level, 0);
    check("flush_ovf", ovf, 0);

    // Full FIFO with a pop in the same clk as a push: pushed entry goes last.
    for (int i = 0; i < 16; i++) push(1'b0, 8'(8'h80 + i), 1);
    check("full_level", level, 16);
    cen_force = 1'b1;
    cpu_we = 1'b1; cpu_addr = 1'b0; cpu_din = 8'hC7;
    step();
    cen_force = 1'b0;
    cpu_we = 1'b0;
    exp_q.push_back({1'b0, 8'hC7});
    check("pushpop_level", level, 16);
    check("pushpop_ovf", ovf, 0);
    cen_mode = 2;
    wait_idle(600, "drain_idle");
    check("drain_sb_empty", exp_q.size(), 0);
    check("drain_last_din", opl_din, 8'hC7);

    // Flush during WAIT with 5 entries queued.
    do_reset();
    cen_mode = 0; cen_force = 1'b0;
    for (int i = 0; i < 6; i++) push(1'b1, 8'(8'h50 + i), 1);
    cen_mode = 2;
    s0 = strobe_cnt; n = 0;
    while (strobe_cnt == s0 && n < 20) begin step(); n++; end
    check("fw_first_strobe", strobe_cnt - s0, 1);
    repeat (5) step();
    check("fw_level_before", level, 5);
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.delete();
    check("fw_level", level, 0);
    check("fw_ovf", ovf, 0);
    check("fw_busy_in_wait", busy, 1);
    wait_idle(200, "fw_wait_done");
    s0 = strobe_cnt;
    repeat (150) step();
    check("fw_no_more_strobes", strobe_cnt - s0, 0);

    // Lone data-port write with cen tied high: total busy time from the push.
    do_reset();
    cen_mode = 2;
    push(1'b1, 8'hFF, 1);
    busy_clk = 0; low_clk = 0; n = 0;
    while (busy && n < 300) begin
      busy_clk++;
      if (!opl_wr_n) low_clk++;
      step(); n++;
    end
    check("lone_busy_clk", busy_clk, DATA_WAIT + 2);
    check("lone_wr_low_clk", low_clk, 1);

    // Reset while the strobe is low, with more writes queued.
    cen_mode = 0; cen_force = 1'b0;
    push(1'b0, 8'h11, 1);
    push(1'b1, 8'h22, 1);
    push(1'b1, 8'h33, 1);
    cen_force = 1'b1; step(); cen_force = 1'b0; step();
    check("mid_strobe_wr_n", opl_wr_n, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_n", opl_wr_n, 1);
    check("arst_cs_n", opl_cs_n, 1);
    check("arst_level", level, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    step();
    rst = 1'b0;
    cen_mode = 2;
    repeat (20) step();
    check("arst_no_replay", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
